// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 scan driver.
// Also used by hub75_scan_driver, which has an optional double-buffer build selected by HUB75_DBUF_EN.
package hub75_pkg;

    // Scan engine states.
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH,
        DISPLAY
    } state_t;

    // Widest colour depth the pixel container can carry.
    // The driver's BPC must not exceed BPC_MAX.
    localparam int BPC_MAX     = 8;
    localparam int PLANE_SEL_W = $clog2(BPC_MAX);

    // One pixel pair (top and bottom half-panel).
    // Each channel is zero-extended to BPC_MAX bits.
    typedef struct packed {
        logic [BPC_MAX-1:0] r_top;
        logic [BPC_MAX-1:0] g_top;
        logic [BPC_MAX-1:0] b_top;
        logic [BPC_MAX-1:0] r_bot;
        logic [BPC_MAX-1:0] g_bot;
        logic [BPC_MAX-1:0] b_bot;
    } pixel_t;

    // Counter width needed to hold values 0..max_value; never returns zero.
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

    // Pick one bit-plane out of a pixel pair, ordered {R1,G1,B1,R2,G2,B2}.
    function automatic logic [5:0] plane_bits(input pixel_t pix, input logic [PLANE_SEL_W-1:0] plane);
        return {pix.r_top[plane], pix.g_top[plane], pix.b_top[plane],
                pix.r_bot[plane], pix.g_bot[plane], pix.b_bot[plane]};
    endfunction

endpackage

// File: rtl/hub75_pixel_ram.sv
// Simple dual-port pixel RAM.
// Synchronous write and registered read.
// A read of the address being written in the same cycle returns the old word.
module hub75_pixel_ram
    import hub75_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic             CLK_MOD,
    input  logic             i_wrEn,
    input  logic [AW-1:0]    i_wrAddr,
    input  logic [WIDTH-1:0] i_wrData,
    input  logic             i_rdEn,
    input  logic [AW-1:0]    i_rdAddr,
    output logic [WIDTH-1:0] o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdData;

    // Store host writes and fetch the requested word; the read data is held while i_rdEn is low.
    always_ff @(posedge CLK_MOD) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
        if (i_rdEn) begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 scan engine with binary-code-modulation brightness.
// HUB75_DBUF_EN selects double buffering:
//   - host writes go to the back bank;
//   - a serviced swap flips the banks at frame end.
// Without HUB75_DBUF_EN there is a single bank, and swap_req/swap_ack only act as a frame-sync handshake.
module hub75_scan_driver
    import hub75_pkg::*;
#(
    parameter int COLS      = 64,
    parameter int ADDR_BITS = 2,
    parameter int BPC       = 4,
    parameter int BASE_ON   = 8
) (
    input  logic                     CLK_MOD,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     wr_en,
    input  logic [ADDR_BITS-1:0]     wr_row,
    input  logic [$clog2(COLS)-1:0]  wr_col,
    input  logic [6*BPC-1:0]         wr_data,
    input  logic                     swap_req,
    output logic                     swap_ack,
    output logic                     frame_start,
    output logic                     R1,
    output logic                     G1,
    output logic                     B1,
    output logic                     R2,
    output logic                     G2,
    output logic                     B2,
    output logic                     CLK_M,
    output logic                     LAT,
    output logic                     OE,
    output logic [ADDR_BITS-1:0]     row_addr
);

    localparam int ROWS  = 1 << ADDR_BITS;
    localparam int COL_W = $clog2(COLS);
    localparam int SH_W  = cnt_width(2*COLS - 1);
    localparam int PL_W  = cnt_width(BPC - 1);
    localparam int DC_W  = cnt_width((BASE_ON << (BPC - 1)) - 1);
`ifdef HUB75_DBUF_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif
    localparam int DEPTH  = NBANK * ROWS * COLS;
    localparam int RAM_AW = cnt_width(DEPTH - 1);

    state_t              r_state, w_stateNext;
    logic [ADDR_BITS-1:0] r_row, w_rowNext;
    logic [PL_W-1:0]     r_plane, w_planeNext;
    logic [SH_W-1:0]     r_shift, w_shiftNext;
    logic [DC_W-1:0]     r_disp, w_dispNext, w_dispLast;
    logic                r_clkM, w_clkMNext;
    logic                r_lat, w_latNext;
    logic                r_oe, w_oeNext;
    logic [ADDR_BITS-1:0] r_rowAddr, w_rowAddrNext;
    logic                r_frameStart, w_frameStartNext;
    logic                r_swapAck, w_swapAckNext;
    logic                r_swapPend, w_swapPendNext;
    logic                w_frameEnd;
    logic                w_wrEn, w_rdEn;
    logic [SH_W-1:0]     w_shiftHalf;
    logic [COL_W-1:0]    w_rdCol;
    logic [RAM_AW-1:0]   w_wrAddr, w_rdAddr;
    logic [6*BPC-1:0]    w_rdData;
    pixel_t              w_pix;
    logic [5:0]          w_rgb;
    logic                w_shifting;
`ifdef HUB75_DBUF_EN
    logic                r_front, w_frontNext;
`endif

    // Next-state, counters, swap bookkeeping and registered panel controls for the state being entered.
    always_comb begin
        w_stateNext      = r_state;
        w_rowNext        = r_row;
        w_planeNext      = r_plane;
        w_shiftNext      = r_shift;
        w_dispNext       = r_disp;
        w_frameEnd       = 1'b0;
        w_frameStartNext = 1'b0;
        w_clkMNext       = 1'b0;
        w_latNext        = 1'b0;
        w_oeNext         = 1'b1;
        w_rowAddrNext    = r_rowAddr;
        w_dispLast       = DC_W'((BASE_ON << r_plane) - 1);
        unique case (r_state)
            IDLE: begin
                if (enable) begin
                    w_stateNext      = SHIFT;
                    w_rowNext        = '0;
                    w_planeNext      = '0;
                    w_shiftNext      = '0;
                    w_frameStartNext = 1'b1;
                end
            end
            SHIFT: begin
                if (r_shift == SH_W'(2*COLS - 1)) begin
                    w_stateNext = LATCH;
                    w_shiftNext = '0;
                end else begin
                    w_shiftNext = r_shift + SH_W'(1);
                end
            end
            LATCH: begin
                w_stateNext = DISPLAY;
                w_dispNext  = '0;
            end
            DISPLAY: begin
                if (r_disp == w_dispLast) begin
                    w_dispNext  = '0;
                    w_shiftNext = '0;
                    w_stateNext = SHIFT;
                    if (r_plane == PL_W'(BPC - 1)) begin
                        w_planeNext = '0;
                        if (r_row == ADDR_BITS'(ROWS - 1)) begin
                            w_rowNext  = '0;
                            w_frameEnd = 1'b1;
                            if (enable) begin
                                w_frameStartNext = 1'b1;
                            end else begin
                                w_stateNext = IDLE;
                            end
                        end else begin
                            w_rowNext = r_row + ADDR_BITS'(1);
                        end
                    end else begin
                        w_planeNext = r_plane + PL_W'(1);
                    end
                end else begin
                    w_dispNext = r_disp + DC_W'(1);
                end
            end
            default: w_stateNext = IDLE;
        endcase
        case (w_stateNext)
            SHIFT: w_clkMNext = w_shiftNext[0];
            LATCH: begin
                w_latNext     = 1'b1;
                w_rowAddrNext = r_row;
            end
            DISPLAY: w_oeNext = 1'b0;
            default: ;
        endcase
        w_swapAckNext  = w_frameEnd & r_swapPend;
        w_swapPendNext = swap_req | (r_swapPend & ~w_frameEnd);
`ifdef HUB75_DBUF_EN
        w_frontNext = r_front ^ w_swapAckNext;
`endif
    end

    // State register and registered panel controls.
    // Reset blanks the panel immediately.
    always_ff @(posedge CLK_MOD or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_row        <= '0;
            r_plane      <= '0;
            r_shift      <= '0;
            r_disp       <= '0;
            r_clkM       <= 1'b0;
            r_lat        <= 1'b0;
            r_oe         <= 1'b1;
            r_rowAddr    <= '0;
            r_frameStart <= 1'b0;
            r_swapAck    <= 1'b0;
            r_swapPend   <= 1'b0;
`ifdef HUB75_DBUF_EN
            r_front      <= 1'b0;
`endif
        end else begin
            r_state      <= w_stateNext;
            r_row        <= w_rowNext;
            r_plane      <= w_planeNext;
            r_shift      <= w_shiftNext;
            r_disp       <= w_dispNext;
            r_clkM       <= w_clkMNext;
            r_lat        <= w_latNext;
            r_oe         <= w_oeNext;
            r_rowAddr    <= w_rowAddrNext;
            r_frameStart <= w_frameStartNext;
            r_swapAck    <= w_swapAckNext;
            r_swapPend   <= w_swapPendNext;
`ifdef HUB75_DBUF_EN
            r_front      <= w_frontNext;
`endif
        end
    end

    // The read is issued on entry to each column's phase 0, so the word is ready while that column is shifted out.
    assign w_wrEn      = wr_en && (int'(wr_col) < COLS);
    assign w_rdEn      = (w_stateNext == SHIFT) && !w_shiftNext[0];
    assign w_shiftHalf = w_shiftNext >> 1;
    assign w_rdCol     = COL_W'(COLS - 1) - COL_W'(w_shiftHalf);
`ifdef HUB75_DBUF_EN
    assign w_wrAddr = RAM_AW'(ROWS*COLS*int'(~r_front) + COLS*int'(wr_row) + int'(wr_col));
    assign w_rdAddr = RAM_AW'(ROWS*COLS*int'(w_frontNext) + COLS*int'(w_rowNext) + int'(w_rdCol));
`else
    assign w_wrAddr = RAM_AW'(COLS*int'(wr_row) + int'(wr_col));
    assign w_rdAddr = RAM_AW'(COLS*int'(w_rowNext) + int'(w_rdCol));
`endif

    hub75_pixel_ram #(
        .WIDTH (6*BPC),
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_pixelRam (
        .CLK_MOD  (CLK_MOD),
        .i_wrEn   (w_wrEn),
        .i_wrAddr (w_wrAddr),
        .i_wrData (wr_data),
        .i_rdEn   (w_rdEn),
        .i_rdAddr (w_rdAddr),
        .o_rdData (w_rdData)
    );

    // Unpack the fetched word and select the current bit-plane for the colour pins.
    always_comb begin
        w_pix       = '0;
        w_pix.r_top = BPC_MAX'(w_rdData[5*BPC +: BPC]);
        w_pix.g_top = BPC_MAX'(w_rdData[4*BPC +: BPC]);
        w_pix.b_top = BPC_MAX'(w_rdData[3*BPC +: BPC]);
        w_pix.r_bot = BPC_MAX'(w_rdData[2*BPC +: BPC]);
        w_pix.g_bot = BPC_MAX'(w_rdData[1*BPC +: BPC]);
        w_pix.b_bot = BPC_MAX'(w_rdData[0 +: BPC]);
        w_rgb       = plane_bits(w_pix, PLANE_SEL_W'(r_plane));
    end

    assign w_shifting  = (r_state == SHIFT);
    assign R1          = w_shifting & w_rgb[5];
    assign G1          = w_shifting & w_rgb[4];
    assign B1          = w_shifting & w_rgb[3];
    assign R2          = w_shifting & w_rgb[2];
    assign G2          = w_shifting & w_rgb[1];
    assign B2          = w_shifting & w_rgb[0];
    assign CLK_M       = r_clkM;
    assign LAT         = r_lat;
    assign OE          = r_oe;
    assign row_addr    = r_rowAddr;
    assign frame_start = r_frameStart;
    assign swap_ack    = r_swapAck;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver with COLS=4, ADDR_BITS=1, BPC=2, BASE_ON=2.
// Expected values are worked out by hand from the frame timeline.
// Each plane takes SHIFT 8 + LATCH 1 + DISPLAY 2/4 cycles, so a frame is 48 cycles.
`timescale 1ns/1ps
module tb_hub75_scan_driver;

    localparam int COLS      = 4;
    localparam int ADDR_BITS = 1;
    localparam int BPC       = 2;
    localparam int BASE_ON   = 2;
`ifdef HUB75_DBUF_EN
    localparam int RGB13_EXP = 0;
`else
    localparam int RGB13_EXP = 63;
`endif

    typedef struct {
        int         cyc;
        logic [4:0] ctrl;
        int         rgb;
    } vec_t;

    logic                 CLK_MOD  = 1'b0;
    logic                 rst      = 1'b0;
    logic                 enable   = 1'b0;
    logic                 wr_en    = 1'b0;
    logic [ADDR_BITS-1:0] wr_row   = '0;
    logic [1:0]           wr_col   = '0;
    logic [6*BPC-1:0]     wr_data  = '0;
    logic                 swap_req = 1'b0;
    logic                 swap_ack, frame_start, R1, G1, B1, R2, G2, B2, CLK_M, LAT, OE;
    logic [ADDR_BITS-1:0] row_addr;

    int checksRun    = 0;
    int checksPassed = 0;
    logic [4:0] trCtrl [0:48];
    int         trRgb  [0:48];

    always #5 CLK_MOD = ~CLK_MOD;

    hub75_scan_driver #(
        .COLS(COLS), .ADDR_BITS(ADDR_BITS), .BPC(BPC), .BASE_ON(BASE_ON)
    ) dut (
        .CLK_MOD(CLK_MOD), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack),
        .frame_start(frame_start), .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
        .CLK_M(CLK_M), .LAT(LAT), .OE(OE), .row_addr(row_addr)
    );

    // Control bits packed as {OE, LAT, CLK_M, row_addr, frame_start}.
    function automatic logic [4:0] ctrlNow();
        return {OE, LAT, CLK_M, row_addr[0], frame_start};
    endfunction

    function automatic int rgbNow();
        return int'({R1, G1, B1, R2, G2, B2});
    endfunction

    function automatic vec_t mkVec(input int c, input logic [4:0] ctl, input int rgb);
        vec_t v;
        v.cyc  = c;
        v.ctrl = ctl;
        v.rgb  = rgb;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checksRun++;
        if (actual == expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One-cycle host write, started and finished on a falling edge.
    task automatic applyStimulus(input int row, input int col, input logic [6*BPC-1:0] data);
        wr_en   = 1'b1;
        wr_row  = ADDR_BITS'(row);
        wr_col  = 2'(col);
        wr_data = data;
        @(negedge CLK_MOD);
        wr_en = 1'b0;
    endtask

    initial begin
        vec_t vecs[$];
        int   ackAt, fsSeen, cnt, acksA, acksB, ackCyc, rgb13, rgb50, fs48, fsLate, oe95, idleBad;

        // Frame-relative expectations; frame 2 starts with row_addr still 1 from frame 1.
        vecs.push_back(mkVec(0,  5'b10011, 63));
        vecs.push_back(mkVec(1,  5'b10110, 63));
        vecs.push_back(mkVec(2,  5'b10010, 0));
        vecs.push_back(mkVec(3,  5'b10110, 0));
        vecs.push_back(mkVec(7,  5'b10110, 0));
        vecs.push_back(mkVec(8,  5'b11000, -1));
        vecs.push_back(mkVec(9,  5'b00000, -1));
        vecs.push_back(mkVec(10, 5'b00000, -1));
        vecs.push_back(mkVec(11, 5'b10000, 63));
        vecs.push_back(mkVec(12, 5'b10100, 63));
        vecs.push_back(mkVec(19, 5'b11000, -1));
        vecs.push_back(mkVec(23, 5'b00000, -1));
        vecs.push_back(mkVec(24, 5'b10000, 0));
        vecs.push_back(mkVec(30, 5'b10000, 16));
        vecs.push_back(mkVec(31, 5'b10100, 16));
        vecs.push_back(mkVec(32, 5'b11010, -1));
        vecs.push_back(mkVec(33, 5'b00010, -1));
        vecs.push_back(mkVec(35, 5'b10010, 0));
        vecs.push_back(mkVec(41, 5'b10010, 32));
        vecs.push_back(mkVec(42, 5'b10110, 32));
        vecs.push_back(mkVec(43, 5'b11010, -1));
        vecs.push_back(mkVec(47, 5'b00010, -1));
        vecs.push_back(mkVec(48, 5'b10011, 63));

        repeat (2) @(negedge CLK_MOD);
        checkOutput("reset ctrl", ctrlNow(), 5'b10000);
        checkOutput("reset rgb", rgbNow(), 0);
        checkOutput("reset swap_ack", swap_ack, 0);
        rst = 1'b1;
        @(negedge CLK_MOD);

        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < COLS; c++) begin
                applyStimulus(r, c, (r == 0 && c == 3) ? 12'hFFF : ((r == 1 && c == 0) ? 12'h900 : 12'h000));
            end
        end
        checkOutput("idle with enable low", ctrlNow(), 5'b10000);

        enable = 1'b1;
        @(negedge CLK_MOD);
        checkOutput("frame_start on enable", frame_start, 1);
        swap_req = 1'b1;
        ackAt = -1;
        for (int k = 1; k <= 60 && ackAt < 0; k++) begin
            @(negedge CLK_MOD);
            swap_req = 1'b0;
            if (swap_ack) ackAt = k;
        end
        checkOutput("first swap_ack cycle", ackAt, 48);
        checkOutput("frame_start with swap_ack", frame_start, 1);

        trCtrl[0] = ctrlNow();
        trRgb[0]  = rgbNow();
        for (int k = 1; k <= 48; k++) begin
            @(negedge CLK_MOD);
            trCtrl[k] = ctrlNow();
            trRgb[k]  = rgbNow();
        end
        foreach (vecs[i]) begin
            checkOutput($sformatf("c%0d ctrl", vecs[i].cyc), trCtrl[vecs[i].cyc], vecs[i].ctrl);
            if (vecs[i].rgb >= 0) begin
                checkOutput($sformatf("c%0d rgb", vecs[i].cyc), trRgb[vecs[i].cyc], vecs[i].rgb);
            end
        end

        cnt = 0;
        for (int k = 1; k <= 10; k++) if (trCtrl[k][2] && !trCtrl[k-1][2]) cnt++;
        checkOutput("CLK_M rises plane0", cnt, 4);
        cnt = 0;
        for (int k = 0; k <= 10; k++) if (trCtrl[k][2] && trRgb[k][5]) cnt++;
        checkOutput("R1 at CLK_M high plane0", cnt, 1);
        cnt = 0;
        for (int k = 0; k <= 10; k++) if (!trCtrl[k][4]) cnt++;
        checkOutput("OE low plane0", cnt, 2);
        cnt = 0;
        for (int k = 11; k <= 23; k++) if (!trCtrl[k][4]) cnt++;
        checkOutput("OE low plane1", cnt, 4);
        cnt = 0;
        for (int k = 1; k <= 48; k++) begin
            if (trCtrl[k][1] != trCtrl[k-1][1]) cnt += (trCtrl[k][4] && trCtrl[k][3]) ? 1 : 100;
        end
        checkOutput("row_addr changes (all at LAT)", cnt, 2);
        cnt = 0;
        for (int k = 1; k <= 47; k++) if (trCtrl[k][0]) cnt++;
        checkOutput("no frame_start mid-frame", cnt, 0);

        acksA = 0; acksB = 0; ackCyc = -1; rgb13 = -1; rgb50 = -1;
        fs48 = 0; fsLate = 0; oe95 = -1; idleBad = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge CLK_MOD);
            if (swap_ack && c <= 50) begin acksA++; ackCyc = c; end
            if (swap_ack && c > 50) acksB++;
            if (c == 13) rgb13 = rgbNow();
            if (c == 48) fs48 = frame_start;
            if (c == 50) rgb50 = rgbNow();
            if (c > 50 && frame_start) fsLate++;
            if (c == 95) oe95 = OE;
            if (c >= 96 && {OE, LAT, CLK_M} != 3'b100) idleBad++;
            case (c)
                1: begin
                    swap_req = 1'b1;
                    wr_en    = 1'b1;
                    wr_row   = '0;
                    wr_col   = 2'd2;
                    wr_data  = 12'hFFF;
                end
                2: begin
                    swap_req = 1'b0;
                    wr_en    = 1'b0;
                end
                5: swap_req = 1'b1;
                6: swap_req = 1'b0;
                50: enable = 1'b0;
                default: ;
            endcase
        end
        checkOutput("merged swap_ack count", acksA, 1);
        checkOutput("merged swap_ack cycle", ackCyc, 48);
        checkOutput("write visibility before swap", rgb13, RGB13_EXP);
        checkOutput("write visible after swap", rgb50, 63);
        checkOutput("frame_start at frame 4", fs48, 1);
        checkOutput("last DISPLAY before stop", oe95, 0);
        checkOutput("idle blanked after stop", idleBad, 0);
        checkOutput("no frame_start after stop", fsLate, 0);
        checkOutput("no swap_ack after stop", acksB, 0);

        enable = 1'b1;
        fsSeen = -1;
        for (int k = 1; k <= 5 && fsSeen < 0; k++) begin
            @(negedge CLK_MOD);
            if (frame_start) fsSeen = k;
        end
        checkOutput("restart frame_start latency", fsSeen, 1);
        repeat (33) @(negedge CLK_MOD);
        checkOutput("mid-DISPLAY row1 ctrl", ctrlNow(), 5'b00010);
        #1 rst = 1'b0;
        #1;
        checkOutput("async reset ctrl", int'({OE, LAT, CLK_M, row_addr[0]}), 4'b1000);
        @(negedge CLK_MOD);
        checkOutput("held in reset", ctrlNow(), 5'b10000);
        rst = 1'b1;
        @(negedge CLK_MOD);
        checkOutput("fresh frame after reset", ctrlNow(), 5'b10001);
        repeat (8) @(negedge CLK_MOD);
        checkOutput("fresh frame LATCH row0", ctrlNow(), 5'b11000);

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
